// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// Clock divider producing a sample tick every CLK_DIV clocks, plus a
// per-bit tick counter that wraps from tick_max back to 0.
module uart_baud_ctr #(
  parameter int CLK_DIV = 27,
  parameter int TICK_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [TICK_W-1:0] tick_max,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  r_div;
  logic [TICK_W-1:0] r_tick_count;

  // tick_count reports the index of the tick currently being signalled
  assign tick       = (r_div == DIV_W'(CLK_DIV - 1));
  assign tick_count = r_tick_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div        <= '0;
      r_tick_count <= '0;
    end else if (clear) begin
      r_div        <= '0;
      r_tick_count <= '0;
    end else if (tick) begin
      r_div        <= '0;
      r_tick_count <= (r_tick_count == tick_max) ? '0 : r_tick_count + TICK_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to add the parity bit, PARITY_ODD and parity_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27,
`ifdef UART_RX_PARITY_EN
  parameter int PARITY_ODD = 0,
`endif
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output rx_state_t            dbg_state
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  rx_state_t r_state, w_state_next;

  logic r_sync1, r_sync2, r_rx_prev;
  logic r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic r_valid, r_ferr;

  logic w_rx, w_tick, w_vote, w_vote_pt, w_clear;
  logic [TICK_W-1:0] w_tick_count;
  logic w_shift_en, w_bit_clr, w_bit_inc, w_load, w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic r_perr, r_par_bad, w_perr_set, w_par_chk;
`endif

  assign w_rx      = r_sync2;
  assign w_vote    = majority3(r_s0, r_s1, w_rx);
  assign w_vote_pt = w_tick && (w_tick_count == TICK_VOTE);

  uart_baud_ctr #(.CLK_DIV(CLK_DIV), .TICK_W(TICK_W)) u_baud (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_clear),
    .tick_max   (TICK_LAST),
    .tick       (w_tick),
    .tick_count (w_tick_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_load       = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_set   = 1'b0;
    w_par_chk    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !w_rx) begin
          w_state_next = ST_START;
          w_bit_clr    = 1'b1;
        end
      end
      ST_START: begin
        if (w_vote_pt) begin
          w_state_next = w_vote ? ST_IDLE : ST_DATA;
          w_bit_clr    = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_vote_pt) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
            w_bit_clr = 1'b1;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_vote_pt) begin
          w_par_chk    = 1'b1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_vote_pt) begin
          if (!w_vote) begin
            w_ferr_set   = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end else if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            // leave at the vote point so a back-to-back start edge is not missed
            w_state_next = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            w_perr_set = r_par_bad;
            w_load     = !r_par_bad;
`else
            w_load     = 1'b1;
`endif
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_tick && (w_tick_count == TICK_LAST) && w_rx) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // WAIT_IDLE restarts its one-bit high timer whenever the line is low
    w_clear = (r_state == ST_IDLE) || w_ferr_set ||
              ((r_state == ST_WAIT_IDLE) && !w_rx);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      if (w_tick && (w_tick_count == TICK_S0)) r_s0 <= w_rx;
      if (w_tick && (w_tick_count == TICK_S1)) r_s1 <= w_rx;
      if (w_shift_en) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      if (w_bit_clr)      r_bit_cnt <= '0;
      else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      if (w_load) r_data <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_ferr_set;
`ifdef UART_RX_PARITY_EN
      r_perr <= w_perr_set;
      if (r_state == ST_IDLE) r_par_bad <= 1'b0;
      else if (w_par_chk)     r_par_bad <= ((^r_shift) ^ w_vote) != 1'(PARITY_ODD);
`endif
    end
  end

  assign data      = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at CLK_DIV=4, OVERSAMPLE=16 (64 clocks/bit).
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic       clock, reset, rx;
  logic [7:0] data;
  logic       rx_valid, frame_err, busy, parity_err;
  rx_state_t  dbg_state;
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .STOP_BITS(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: outputs sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid || frame_err || parity_err)
        check("pulse_exclusive", 32'(rx_valid) + 32'(frame_err) + 32'(parity_err), 1);
      if (rx_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else                   check("rx_data", 32'(data), 32'(exp_q.pop_front()));
      end
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
    end
  end

  // driver tasks (all called on a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                            input int gbit, input int gpos);
    logic seq[12];
    int n;
    n = 0;
    seq[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin seq[n] = d[i]; n++; end
`ifdef UART_RX_PARITY_EN
    seq[n] = (^d) ^ par_flip; n++;
`else
    if (par_flip) $display("note: parity flip ignored in this build");
`endif
    seq[n] = stop_v; n++;
    start_cyc = cyc;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < BIT_CLKS; c++) begin
        rx = (b == gbit + 1 && c == gpos) ? ~seq[b] : seq[b];
        @(negedge clock);
      end
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop_v;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] model_data;
  int v0, f0, p0, exp_ferr;
  logic [7:0] rd;
  logic       rs;

  initial begin
    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};
    model_data = 8'h00;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clock);
    check("reset_busy", 32'(busy), 0);
    check("reset_data", 32'(data), 0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_pulses", 32'(rx_valid | frame_err | parity_err), 0);
    reset = 1'b0;
    idle(10);

    // table-driven frames
    foreach (vecs[i]) begin
      v0 = n_valid; f0 = n_ferr;
      if (vecs[i].stop_v) exp_q.push_back(vecs[i].d);
      send_frame(vecs[i].d, vecs[i].stop_v, 1'b0, -2, 0);
      idle(100);
      if (vecs[i].stop_v) begin
        model_data = vecs[i].d;
        check("vec_latency_window",
              32'((last_valid_cyc - start_cyc) >= 600 && (last_valid_cyc - start_cyc) <= 640), 1);
      end
      check("vec_valid_count", 32'(n_valid - v0), 32'(vecs[i].stop_v));
      check("vec_ferr_count", 32'(n_ferr - f0), 32'(!vecs[i].stop_v));
      check("vec_data", 32'(data), 32'(model_data));
      check("vec_busy_after", 32'(busy), 0);
    end

    // short low pulse: rejected as a glitch at the start vote
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    rx = 1'b0; idle(10);
    check("glitch_busy_high", 32'(busy), 1);
    idle(10); rx = 1'b1; idle(60);
    check("glitch_busy_low", 32'(busy), 0);
    check("glitch_no_pulse", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 0);

    // bad stop bit followed by a break, then recovery
    f0 = n_ferr; v0 = n_valid;
    send_frame(8'h3C, 1'b0, 1'b0, -2, 0);
    rx = 1'b0; idle(3 * BIT_CLKS);
    check("break_busy", 32'(busy), 1);
    rx = 1'b1; idle(BIT_CLKS + 16);
    check("break_one_ferr", 32'(n_ferr - f0), 1);
    check("break_data_kept", 32'(data), 32'(model_data));
    check("break_back_idle", 32'(busy), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, -2, 0);
    idle(100);
    model_data = 8'h55;
    check("after_break_data", 32'(data), 32'h55);
    check("after_break_valid", 32'(n_valid - v0), 1);

    // one-clock inverted glitch around tick 8 of data bit 3
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b0, 3, 36);
    idle(100);
    model_data = 8'hF0;
    check("bit_glitch_data", 32'(data), 32'hF0);

    // reset in the middle of bit 4
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0; idle(BIT_CLKS);
    for (int b = 0; b < 4; b++) begin rx = 1'b0; idle(BIT_CLKS); end
    idle(30);
    reset = 1'b1; rx = 1'b1;
    #1;
    check("midreset_busy_async", 32'(busy), 0);
    idle(3);
    check("midreset_data", 32'(data), 0);
    reset = 1'b0;
    model_data = 8'h00;
    idle(BIT_CLKS * 2);
    check("midreset_no_pulse", 32'((n_valid - v0) + (n_ferr - f0)), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, -2, 0);
    idle(100);
    model_data = 8'h81;
    check("midreset_next_data", 32'(data), 32'h81);
    check("midreset_next_valid", 32'(n_valid - v0), 1);

`ifdef UART_RX_PARITY_EN
    // even parity: 8'h07 has three ones, so the correct parity bit is 1
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, -2, 0);
    idle(100);
    check("parity_bad_perr", 32'(n_perr - p0), 1);
    check("parity_bad_no_valid", 32'(n_valid - v0), 0);
    check("parity_bad_data_kept", 32'(data), 32'(model_data));
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, -2, 0);
    idle(100);
    model_data = 8'h07;
    check("parity_ok_valid", 32'(n_valid - v0), 1);
    check("parity_ok_data", 32'(data), 32'h07);
`endif

    // random frames against the reference model
    f0 = n_ferr; exp_ferr = 0;
    for (int k = 0; k < 16; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      if (rs) begin
        exp_q.push_back(rd);
        model_data = rd;
      end else begin
        exp_ferr++;
      end
      send_frame(rd, rs, 1'b0, -2, 0);
      if (rs) idle($urandom_range(0, 30));
      else    idle(BIT_CLKS + 10 + $urandom_range(0, 30));
    end
    idle(100);
    check("rand_ferr_count", 32'(n_ferr - f0), 32'(exp_ferr));
    check("rand_final_data", 32'(data), 32'(model_data));
    check("rand_queue_drained", 32'(exp_q.size()), 0);
    check("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
